// File: rtl/storage_ram_dp_pkg.sv
// ============================================================================
// storage_ram_dp_pkg : shared types and helpers for the dual-port storage RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

package storage_ram_dp_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR    = 2'd0,
    ST_IDLE_RUN = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  localparam int c_BYTE_W = 8;

  function automatic int byte_lanes(input int data_width);
    return data_width / c_BYTE_W;
  endfunction

  function automatic int read_latency(input int out_reg);
    return 1 + out_reg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/storage_ram_core.sv
// ============================================================================
// storage_ram_core : raw simple-dual-port array, byte-enable write, registered read
// Revision: 1.0
// ============================================================================
`default_nettype none

module storage_ram_core
  import storage_ram_dp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int c_LANES = byte_lanes(DATA_WIDTH);
  localparam int c_DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  // No reset here so the array and read register map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < c_LANES; i++) begin
        if (wbe[i]) begin
          r_mem[waddr][c_BYTE_W*i +: c_BYTE_W] <= wdata[c_BYTE_W*i +: c_BYTE_W];
        end
      end
    end
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/storage_ram_dp.sv
// ============================================================================
// storage_ram_dp : simple dual-port storage RAM with clear sweep, byte enables,
//                  read-valid handshake, optional output register
// Revision: 1.0
// ============================================================================
`default_nettype none

module storage_ram_dp
  import storage_ram_dp_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    OUT_REG        = 0,
  parameter int                    RDW_NEW        = 1,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    ready
);

  localparam int c_LANES   = byte_lanes(DATA_WIDTH);
  localparam int c_LATENCY = read_latency(OUT_REG);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [ADDR_WIDTH:0]     r_clr_cnt;
  logic [ADDR_WIDTH:0]     w_clr_cnt_nxt;
  logic                    w_clr_we;
  logic                    w_ready;
  logic                    w_wr_acc;
  logic                    w_rd_acc;

  logic                    w_mem_we;
  logic [ADDR_WIDTH-1:0]   w_mem_waddr;
  logic [DATA_WIDTH-1:0]   w_mem_wdata;
  logic [c_LANES-1:0]      w_mem_wbe;
  logic [DATA_WIDTH-1:0]   w_core_rdata;

  logic                    r_vld1;
  logic                    r_col_hit;
  logic [DATA_WIDTH-1:0]   r_col_data;
  logic [c_LANES-1:0]      r_col_be;
  logic [DATA_WIDTH-1:0]   w_rd_word;

  // ---------------------------------------------------------------- clear FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE_RUN;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clr_we      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we      = rst_n;
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        // MSB of the widened counter flags that the last word was just written.
        if (w_clr_cnt_nxt[ADDR_WIDTH]) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_IDLE_RUN: w_state_nxt = ST_RUN;
      ST_RUN:      w_state_nxt = ST_RUN;
      default:     w_state_nxt = ST_RUN;
    endcase
  end

  assign w_ready  = (r_state == ST_RUN);
  assign ready    = w_ready;
  assign w_wr_acc = w_ready & wr_en;
  assign w_rd_acc = w_ready & rd_en;

  // ---------------------------------------------------------------- write mux
  assign w_mem_we    = w_clr_we | w_wr_acc;
  assign w_mem_waddr = w_clr_we ? r_clr_cnt[ADDR_WIDTH-1:0] : wr_addr;
  assign w_mem_wdata = w_clr_we ? CLEAR_VALUE : wr_data;
  assign w_mem_wbe   = w_clr_we ? {c_LANES{1'b1}} : wr_be;

  storage_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk   (clk),
    .we    (w_mem_we),
    .waddr (w_mem_waddr),
    .wdata (w_mem_wdata),
    .wbe   (w_mem_wbe),
    .re    (w_rd_acc),
    .raddr (rd_addr),
    .rdata (w_core_rdata)
  );

  // ------------------------------------------------------ collision / valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld1    <= 1'b0;
      r_col_hit <= 1'b0;
    end else begin
      r_vld1 <= w_rd_acc;
      if (w_rd_acc) begin
        r_col_hit <= w_wr_acc && (wr_addr == rd_addr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_acc) begin
      r_col_data <= wr_data;
      r_col_be   <= wr_be;
    end
  end

  // The core returns the pre-write word; splice in the colliding bytes if asked.
  for (genvar i = 0; i < c_LANES; i++) begin : g_merge
    assign w_rd_word[c_BYTE_W*i +: c_BYTE_W] =
      ((RDW_NEW != 0) && r_col_hit && r_col_be[i]) ? r_col_data[c_BYTE_W*i +: c_BYTE_W]
                                                   : w_core_rdata[c_BYTE_W*i +: c_BYTE_W];
  end

  // ------------------------------------------------------------- output stage
  if (c_LATENCY == 1) begin : g_out_direct
    logic r_rd_seen;

    // The core register has no reset, so mask it until the first read lands.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_rd_seen <= 1'b0;
      end else if (w_rd_acc) begin
        r_rd_seen <= 1'b1;
      end
    end

    assign rd_data  = r_rd_seen ? w_rd_word : '0;
    assign rd_valid = r_vld1;
  end else begin : g_out_reg
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_vld2;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_rd_data <= '0;
        r_vld2    <= 1'b0;
      end else begin
        r_vld2 <= r_vld1;
        if (r_vld1) begin
          r_rd_data <= w_rd_word;
        end
      end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_vld2;
  end

endmodule

`default_nettype wire

// File: tb/tb_storage_ram_dp.sv
// ============================================================================
// tb_storage_ram_dp : scoreboard bench driving two configurations in lockstep
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_storage_ram_dp;

  localparam int          c_DW    = 16;
  localparam int          c_AW    = 4;
  localparam int          c_DEPTH = 16;
  localparam logic [15:0] c_CLR   = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;

  logic [15:0] rd_data_w  [2];
  logic        rd_valid_w [2];
  logic        ready_w    [2];

  // dut 0: latency 1, new-data collisions; dut 1: latency 2, old-data collisions
  storage_ram_dp #(
    .DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .OUT_REG(0), .RDW_NEW(1),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(c_CLR)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w[0]),
    .rd_valid(rd_valid_w[0]), .ready(ready_w[0])
  );

  storage_ram_dp #(
    .DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .OUT_REG(1), .RDW_NEW(0),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(c_CLR)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w[1]),
    .rd_valid(rd_valid_w[1]), .ready(ready_w[1])
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          cyc;
  } exp_t;

  exp_t        sb [2][$];
  int          cyc = 0;
  logic        rst_at_edge = 1'b0;
  logic [15:0] hold [2];
  logic [15:0] mem_m [c_DEPTH];
  bit          model_ready = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst_n;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every rd_valid, checks hold otherwise.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_at_edge) begin
        check($sformatf("rst_valid[%0d]", d), {31'd0, rd_valid_w[d]}, 32'd0);
        check($sformatf("rst_data[%0d]", d), {16'd0, rd_data_w[d]}, 32'd0);
        check($sformatf("rst_ready[%0d]", d), {31'd0, ready_w[d]}, 32'd0);
        sb[d].delete();
        hold[d] = '0;
      end else if (rd_valid_w[d]) begin
        if (sb[d].size() == 0) begin
          check($sformatf("spurious_valid[%0d]", d), 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb[d].pop_front();
          check($sformatf("rd_data[%0d]", d), {16'd0, rd_data_w[d]}, {16'd0, e.d});
          check($sformatf("rd_latency[%0d]", d), cyc, e.cyc);
          hold[d] = e.d;
        end
      end else begin
        check($sformatf("rd_hold[%0d]", d), {16'd0, rd_data_w[d]}, {16'd0, hold[d]});
        if (sb[d].size() > 0 && sb[d][0].cyc <= cyc) begin
          check($sformatf("missing_valid[%0d]", d), 32'd0, 32'd1);
          void'(sb[d].pop_front());
        end
      end
    end
  end

  task automatic cyc_drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                           input logic [1:0] wbe, input logic re, input logic [3:0] ra);
    logic [15:0] old_v;
    logic [15:0] new_v;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    wr_be   = wbe;
    rd_en   = re;
    rd_addr = ra;
    if (model_ready) begin
      old_v = mem_m[ra];
      if (we) begin
        for (int i = 0; i < 2; i++) begin
          if (wbe[i]) mem_m[wa][8*i +: 8] = wd[8*i +: 8];
        end
      end
      new_v = mem_m[ra];
      if (re) begin
        sb[0].push_back(exp_t'{new_v, cyc + 1});
        sb[1].push_back(exp_t'{old_v, cyc + 2});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc_drive(1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 4'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    cyc_drive(1'b1, a, d, be, 1'b0, 4'd0);
  endtask

  task automatic rd(input logic [3:0] a);
    cyc_drive(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, a);
  endtask

  // Counts cycles from reset release to ready; optionally pokes requests mid-sweep.
  task automatic wait_ready(input bit poke);
    int n;
    int na;
    int nb;
    n  = 0;
    na = 0;
    nb = 0;
    while (n < 64 && (na == 0 || nb == 0)) begin
      if (poke && n >= 2 && n < 5) cyc_drive(1'b1, 4'd3, 16'h1111, 2'b11, 1'b1, 4'd3);
      else idle();
      n++;
      if (ready_w[0] && na == 0) na = n;
      if (ready_w[1] && nb == 0) nb = n;
    end
    check("ready_latency[0]", na, 16);
    check("ready_latency[1]", nb, 16);
    for (int a = 0; a < c_DEPTH; a++) mem_m[a] = c_CLR;
    model_ready = 1'b1;
  endtask

  initial begin
    hold[0] = '0;
    hold[1] = '0;
    for (int a = 0; a < c_DEPTH; a++) mem_m[a] = 'x;

    rst_n = 1'b0;
    repeat (3) idle();
    rst_n = 1'b1;
    wait_ready(1'b1);
    for (int a = 0; a < c_DEPTH; a++) rd(4'(a));

    wr(4'h5, 16'h1234, 2'b11);
    wr(4'h5, 16'hFFEE, 2'b01);
    wr(4'h5, 16'h0000, 2'b00);
    rd(4'h5);

    wr(4'h7, 16'h0000, 2'b11);
    cyc_drive(1'b1, 4'h7, 16'hBEEF, 2'b11, 1'b1, 4'h7);
    rd(4'h7);
    cyc_drive(1'b1, 4'h7, 16'hCC33, 2'b10, 1'b1, 4'h7);
    rd(4'h7);
    cyc_drive(1'b1, 4'h8, 16'h5555, 2'b11, 1'b1, 4'h7);
    rd(4'h8);

    for (int a = 0; a < 8; a++) wr(4'(a), 16'(a * 3), 2'b11);
    for (int a = 0; a < 8; a++) rd(4'(a));
    repeat (4) idle();

    rst_n       = 1'b0;
    model_ready = 1'b0;
    repeat (2) idle();
    rst_n = 1'b1;
    repeat (9) idle();
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    wait_ready(1'b0);
    for (int a = 0; a < c_DEPTH; a++) rd(4'(a));
    repeat (4) idle();

    check("sb_drained[0]", sb[0].size(), 0);
    check("sb_drained[1]", sb[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
